bike_motion_ctrl: RTL and testbench

//  Producer of the packed 32-bit bike word consumed by the VGA display path.

---
 rtl/bike_motion_ctrl_pkg.sv | 42 ++++
 rtl/bike_motion_ctrl_xy_to_addr.sv | 20 ++
 rtl/bike_motion_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_bike_motion_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bike_motion_ctrl_pkg.sv
// bike_motion_ctrl_pkg
//   Constants shared by the bike motion controller, the display decoder and
//   the collision logic. It holds the screen geometry, the orientation codes,
//   the field layout of the packed bike word and the FSM state codes. It also
//   provides a helper that assembles the packed bike word.
package bike_motion_ctrl_pkg;

  localparam int H_ACT  = 640;
  localparam int V_ACT  = 480;
  localparam int SPRITE = 30;

  // Largest legal top-left coordinate. The sprite must stay fully on screen.
  localparam int X_MAX = H_ACT - SPRITE;
  localparam int Y_MAX = V_ACT - SPRITE;

  localparam logic [1:0] ORI_UP    = 2'b00;
  localparam logic [1:0] ORI_RIGHT = 2'b01;
  localparam logic [1:0] ORI_DOWN  = 2'b10;
  localparam logic [1:0] ORI_LEFT  = 2'b11;

  localparam int ORI_LSB   = 0;
  localparam int ADDR_LSB  = 2;
  localparam int ALIVE_BIT = 21;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_CRASH = 2'b10;

  // Layout: [1:0] orientation, [20:2] pixel address, [21] alive.
  // Bits [31:22] are zero.
  function automatic logic [31:0] pack_bike(input logic [18:0] addr,
                                            input logic [1:0]  ori,
                                            input logic        alive);
    logic [31:0] w;
    w = '0;
    w[ORI_LSB +: 2]   = ori;
    w[ADDR_LSB +: 19] = addr;
    w[ALIVE_BIT]      = alive;
    return w;
  endfunction

endpackage

// File: rtl/bike_motion_ctrl_xy_to_addr.sv
// xy_to_addr
//   Converts a top-left pixel coordinate into a linear frame-buffer address.
//   The address is y*640 + x. It is computed with shifts and adds, with no
//   multiplier.
//   Ports:
//     x    in  10  column, 0..639
//     y    in   9  row, 0..479
//     addr out 19  y*640 + x. The maximum is 307199, which fits in 19 bits.
module xy_to_addr
  import bike_motion_ctrl_pkg::*;
(
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  output logic [18:0] addr
);

  // 640 = 512 + 128
  assign addr = {1'b0, y, 9'd0} + {3'd0, y, 7'd0} + {9'd0, x};

endmodule

// File: rtl/bike_motion_ctrl.sv
// bike_motion_ctrl
//   Holds the bike position and orientation, and applies the latched turn
//   requests. It advances the bike STEP px once per frame, on the falling
//   edge of VS. The result is published as the packed 32-bit bike word that
//   the VGA display path reads.
//   Ports:
//     iVGA_CLK in   1  pixel clock
//     iRST_n   in   1  asynchronous reset, active low
//     iVS      in   1  vertical sync, active low, iVGA_CLK domain
//     iStart   in   1  pulse: begin or restart a run
//     iTurnL   in   1  pulse: turn counter-clockwise
//     iTurnR   in   1  pulse: turn clockwise
//     bluebike out 32  [1:0] orient, [20:2] address, [21] alive
//     oCrash   out  1  high while crashed
//     oFrames  out 16  frames survived in this run, saturating
module bike_motion_ctrl
  import bike_motion_ctrl_pkg::*;
#(
  parameter int         STEP = 2,
  parameter int         X0   = 305,
  parameter int         Y0   = 225,
  parameter logic [1:0] O0   = 2'b01,
  parameter bit         WRAP = 1'b1
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iVS,
  input  logic        iStart,
  input  logic        iTurnL,
  input  logic        iTurnR,
  output logic [31:0] bluebike,
  output logic        oCrash,
  output logic [15:0] oFrames
);

  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [10:0] X_LIM    = 11'(X_MAX);
  localparam logic [10:0] Y_LIM    = 11'(Y_MAX);
  localparam logic [9:0]  X_START  = 10'(X0);
  localparam logic [8:0]  Y_START  = 9'(Y0);
  localparam logic [18:0] RST_ADDR = 19'(Y0 * H_ACT + X0);
  localparam logic [31:0] BIKE_RST = pack_bike(RST_ADDR, O0, 1'b0);

  logic        vs_q, vs_d;
  logic        turn_l_q, turn_l_d;
  logic        turn_r_q, turn_r_d;
  logic [1:0]  state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [1:0]  orient_q, orient_d;
  logic [15:0] frames_q, frames_d;
  logic [31:0] bluebike_q, bluebike_d;
  logic        crash_q, crash_d;

  logic        tick;
  logic [1:0]  o_next;
  logic [10:0] x_wide, y_wide;
  logic [9:0]  x_new;
  logic [8:0]  y_new;
  logic        hit;
  logic [18:0] addr;

  // The address is built from the registered position. The bike word
  // therefore trails the position update by one cycle, and no input
  // reaches an output combinationally.
  xy_to_addr u_xy_to_addr (
    .x    (x_q),
    .y    (y_q),
    .addr (addr)
  );

  always_comb begin
    vs_d       = iVS;
    turn_l_d   = turn_l_q;
    turn_r_d   = turn_r_q;
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    orient_d   = orient_q;
    frames_d   = frames_q;
    o_next     = orient_q;
    x_new      = x_q;
    y_new      = y_q;
    hit        = 1'b0;
    x_wide     = {1'b0, x_q};
    y_wide     = {2'b0, y_q};

    tick = vs_q & ~iVS;

    // A turn pulse that arrives in the tick cycle is kept for the next
    // frame. The tick only acts on turns latched before it.
    if (tick) begin
      turn_l_d = iTurnL;
      turn_r_d = iTurnR;
    end else begin
      turn_l_d = turn_l_q | iTurnL;
      turn_r_d = turn_r_q | iTurnR;
    end

    // Opposite requests in the same frame cancel each other.
    if (turn_r_q && !turn_l_q) begin
      o_next = orient_q + 2'd1;
    end else if (turn_l_q && !turn_r_q) begin
      o_next = orient_q - 2'd1;
    end

    // Candidate move in the new orientation. hit flags a step that would
    // leave the legal range.
    case (o_next)
      ORI_RIGHT: begin
        if (x_wide + STEP_W > X_LIM) begin
          hit   = 1'b1;
          x_new = 10'd0;
        end else begin
          x_new = 10'(x_wide + STEP_W);
        end
      end
      ORI_LEFT: begin
        if (x_wide < STEP_W) begin
          hit   = 1'b1;
          x_new = 10'(X_LIM);
        end else begin
          x_new = 10'(x_wide - STEP_W);
        end
      end
      ORI_DOWN: begin
        if (y_wide + STEP_W > Y_LIM) begin
          hit   = 1'b1;
          y_new = 9'd0;
        end else begin
          y_new = 9'(y_wide + STEP_W);
        end
      end
      default: begin
        if (y_wide < STEP_W) begin
          hit   = 1'b1;
          y_new = 9'(Y_LIM);
        end else begin
          y_new = 9'(y_wide - STEP_W);
        end
      end
    endcase

    // A crash freezes the pre-move position and orientation. The frame
    // that ends in a crash is not counted as survived.
    case (state_q)
      ST_IDLE: begin
        if (iStart) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tick) begin
          if (hit && !WRAP) begin
            state_d = ST_CRASH;
          end else begin
            orient_d = o_next;
            x_d      = x_new;
            y_d      = y_new;
            frames_d = (frames_q == 16'hFFFF) ? frames_q : frames_q + 16'd1;
          end
        end
      end
      ST_CRASH: begin
        if (iStart) begin
          state_d  = ST_RUN;
          x_d      = X_START;
          y_d      = Y_START;
          orient_d = O0;
          frames_d = 16'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    bluebike_d = pack_bike(addr, orient_q, state_q == ST_RUN);
    crash_d    = (state_q == ST_CRASH);
  end

  // vs_q resets low, so a VS line that is idle high after reset does not
  // produce a spurious tick.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q       <= 1'b0;
      turn_l_q   <= 1'b0;
      turn_r_q   <= 1'b0;
      state_q    <= ST_IDLE;
      x_q        <= X_START;
      y_q        <= Y_START;
      orient_q   <= O0;
      frames_q   <= 16'd0;
      bluebike_q <= BIKE_RST;
      crash_q    <= 1'b0;
    end else begin
      vs_q       <= vs_d;
      turn_l_q   <= turn_l_d;
      turn_r_q   <= turn_r_d;
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      orient_q   <= orient_d;
      frames_q   <= frames_d;
      bluebike_q <= bluebike_d;
      crash_q    <= crash_d;
    end
  end

  assign bluebike = bluebike_q;
  assign oCrash   = crash_q;
  assign oFrames  = frames_q;

endmodule

// File: tb/tb_bike_motion_ctrl.sv
// tb_bike_motion_ctrl
//   Directed bench for bike_motion_ctrl. It uses two instances:
//     dut_a: default parameters (wrapping edges). Covers motion, turns, both
//            wrap directions and asynchronous reset.
//     dut_b: WRAP=0. Covers crashing at the right edge and restart.
//   Expected words are built from hand-computed coordinates with
//   addr = y*640 + x.
module tb_bike_motion_ctrl;

  logic        iVGA_CLK;
  logic        iRST_n;
  logic        iVS;
  logic        start_a, start_b;
  logic        turn_l, turn_r;
  logic [31:0] bike_a, bike_b;
  logic        crash_a, crash_b;
  logic [15:0] frames_a, frames_b;

  int compared   = 0;
  int mismatched = 0;

  bike_motion_ctrl dut_a (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .iVS      (iVS),
    .iStart   (start_a),
    .iTurnL   (turn_l),
    .iTurnR   (turn_r),
    .bluebike (bike_a),
    .oCrash   (crash_a),
    .oFrames  (frames_a)
  );

  bike_motion_ctrl #(.WRAP(1'b0)) dut_b (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .iVS      (iVS),
    .iStart   (start_b),
    .iTurnL   (1'b0),
    .iTurnR   (1'b0),
    .bluebike (bike_b),
    .oCrash   (crash_b),
    .oFrames  (frames_b)
  );

  // 100 MHz pixel clock for simulation purposes.
  initial iVGA_CLK = 1'b0;
  always #5 iVGA_CLK = ~iVGA_CLK;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] expWord(input int x, input int y,
                                          input int o, input bit alive);
    return (32'(alive) << 21) | (32'(y * 640 + x) << 2) | 32'(o);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Optional one-cycle pulses followed by `ticks` frames. Each frame drops VS
  // for two cycles and then raises it for two. When withTick is set, the
  // pulses share the cycle with the first VS fall instead of preceding it.
  task automatic applyStimulus(input logic sa, input logic sb, input logic tl,
                               input logic tr, input bit withTick,
                               input int ticks);
    if (!withTick && (sa | sb | tl | tr)) begin
      @(negedge iVGA_CLK);
      start_a = sa; start_b = sb; turn_l = tl; turn_r = tr;
      @(negedge iVGA_CLK);
      start_a = 1'b0; start_b = 1'b0; turn_l = 1'b0; turn_r = 1'b0;
      repeat (2) @(negedge iVGA_CLK);
    end
    for (int i = 0; i < ticks; i++) begin
      @(negedge iVGA_CLK);
      iVS = 1'b0;
      if (withTick && i == 0) begin
        start_a = sa; start_b = sb; turn_l = tl; turn_r = tr;
      end
      @(negedge iVGA_CLK);
      start_a = 1'b0; start_b = 1'b0; turn_l = 1'b0; turn_r = 1'b0;
      @(negedge iVGA_CLK);
      iVS = 1'b1;
      repeat (2) @(negedge iVGA_CLK);
    end
  endtask

  initial begin
    iRST_n  = 1'b0;
    iVS     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    turn_l  = 1'b0;
    turn_r  = 1'b0;
    repeat (3) @(negedge iVGA_CLK);
    checkOutput("rst_in_reset", bike_a, 32'h0008CEC5);
    iRST_n = 1'b1;
    repeat (2) @(negedge iVGA_CLK);

    // Reset state
    checkOutput("rst_bike_a", bike_a, 32'h0008CEC5);
    checkOutput("rst_crash_a", {31'd0, crash_a}, 32'd0);
    checkOutput("rst_frames_a", {16'd0, frames_a}, 32'd0);
    checkOutput("rst_bike_b", bike_b, 32'h0008CEC5);

    // Idle: ticks and a turn request have no visible effect.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    checkOutput("idle_bike", bike_a, 32'h0008CEC5);
    checkOutput("idle_frames", {16'd0, frames_a}, 32'd0);

    // Start, then one frame. The idle turn latch was cleared, so the bike
    // keeps heading right.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("start_bike", bike_a, 32'h0028CECD);
    checkOutput("start_frames", {16'd0, frames_a}, 32'd1);

    // Counter-clockwise turn: heading up.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("turnl_bike", bike_a, expWord(307, 223, 0, 1'b1));
    checkOutput("turnl_addr", {13'd0, bike_a[20:2]}, 32'd143027);

    // Both turns in one frame cancel.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    checkOutput("cancel_bike", bike_a, expWord(307, 221, 0, 1'b1));
    checkOutput("cancel_frames", {16'd0, frames_a}, 32'd3);

    // Upward wrap, first from y=1 and later from y=0.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 110);
    checkOutput("up_y1", bike_a, expWord(307, 1, 0, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("wrap_up_y1", bike_a, expWord(307, 450, 0, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 225);
    checkOutput("up_y0", bike_a, expWord(307, 0, 0, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("wrap_up_y0", bike_a, expWord(307, 450, 0, 1'b1));
    checkOutput("wrap_up_frames", {16'd0, frames_a}, 32'd340);

    // Turn right, then rightward wrap from x=609 and from x=610.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("turnr_bike", bike_a, expWord(309, 450, 1, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 150);
    checkOutput("right_x609", bike_a, expWord(609, 450, 1, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("wrap_right_609", bike_a, expWord(0, 450, 1, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 305);
    checkOutput("right_x610", bike_a, expWord(610, 450, 1, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("wrap_right_610", bike_a, expWord(0, 450, 1, 1'b1));

    // Downward wrap from y=450, then leftward wrap from x=0.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("wrap_down", bike_a, expWord(0, 0, 2, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("wrap_left", bike_a, expWord(610, 0, 3, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("left_step", bike_a, expWord(608, 0, 3, 1'b1));

    // A turn pulse in the tick cycle only takes effect one frame later.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    checkOutput("sametick_defer", bike_a, expWord(606, 0, 3, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("sametick_apply", bike_a, expWord(606, 450, 0, 1'b1));

    // Start during a run is ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("start_in_run", bike_a, expWord(606, 448, 0, 1'b1));
    checkOutput("run_frames", {16'd0, frames_a}, 32'd804);
    checkOutput("run_crash_a", {31'd0, crash_a}, 32'd0);

    // Instance with WRAP=0: run right until x=609, then crash on the next step.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 152);
    checkOutput("b_x609", bike_b, expWord(609, 225, 1, 1'b1));
    checkOutput("b_frames152", {16'd0, frames_b}, 32'd152);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("b_crash_bike", bike_b, expWord(609, 225, 1, 1'b0));
    checkOutput("b_crash_flag", {31'd0, crash_b}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("b_crash_hold", bike_b, expWord(609, 225, 1, 1'b0));
    checkOutput("b_crash_frames", {16'd0, frames_b}, 32'd152);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("b_restart_bike", bike_b, expWord(305, 225, 1, 1'b1));
    checkOutput("b_restart_frames", {16'd0, frames_b}, 32'd0);
    checkOutput("b_restart_crash", {31'd0, crash_b}, 32'd0);

    // Asynchronous reset asserted mid-cycle during a run.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    @(negedge iVGA_CLK);
    #2 iRST_n = 1'b0;
    #1;
    checkOutput("async_rst_bike", bike_a, 32'h0008CEC5);
    checkOutput("async_rst_frames", {16'd0, frames_a}, 32'd0);
    checkOutput("async_rst_crash", {31'd0, crash_a}, 32'd0);
    @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("post_rst_bike", bike_a, 32'h0008CEC5);
    checkOutput("post_rst_frames", {16'd0, frames_a}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
